// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, NOP value and fetch FSM encoding
package fetch_stage_pkg;

  localparam int unsigned DS_DEF = 4;
  localparam int unsigned AW_DEF = 16;
  localparam int unsigned IW_DEF = 16;

  localparam logic [IW_DEF-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry skid buffer for a fetched instruction and its PC
module fetch_skid_buf #(
  parameter int unsigned AW = 16,
  parameter int unsigned IW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          drain_i,
  input  logic          clear_i,
  input  logic [AW-1:0] pc_i,
  input  logic [IW-1:0] data_i,
  output logic          valid_o,
  output logic [AW-1:0] pc_o,
  output logic [IW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] data_q, data_d;

  // Clear beats load beats drain; payload only changes on load.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned   DS       = DS_DEF,
  parameter int unsigned   AW       = AW_DEF,
  parameter int unsigned   IW       = IW_DEF,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          pc_write_i,
  input  logic          if_id_write_i,
  input  logic          if_id_flash_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_ack_i,
  input  logic [IW-1:0] imem_rdata_i,
  output logic          if_id_valid_o,
  output logic [AW-1:0] if_id_pc_o,
  output logic [IW-1:0] if_id_instr_o,
  output logic [DS-1:0] if_id_op1_o,
  output logic [DS-1:0] if_id_op2_o
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          ifid_valid_q, ifid_valid_d;
  logic [AW-1:0] ifid_pc_q, ifid_pc_d;
  logic [IW-1:0] ifid_instr_q, ifid_instr_d;

  logic          fetch_ok;
  logic          skid_load, skid_drain, skid_clear;
  logic          skid_valid;
  logic [AW-1:0] skid_pc;
  logic [IW-1:0] skid_data;

  fetch_skid_buf #(
    .AW (AW),
    .IW (IW)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (skid_clear),
    .pc_i    (pc_q),
    .data_i  (imem_rdata_i),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .data_o  (skid_data)
  );

  // Fetch FSM: next state, next PC, memory request and skid control.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imem_req_o = 1'b0;
    fetch_ok   = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_WAIT;
      ST_WAIT: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          if (redirect_i) begin
            pc_d = redirect_pc_i;
          end else begin
            if (pc_write_i) pc_d = pc_q + AW'(1);
            if (if_id_write_i) begin
              fetch_ok = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = ST_HOLD;
            end
          end
        end else if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (redirect_i || if_id_flash_i) begin
          skid_clear = 1'b1;
          if (redirect_i) pc_d = redirect_pc_i;
          state_d = ST_WAIT;
        end else if (if_id_write_i) begin
          skid_drain = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (redirect_i) pc_d = redirect_pc_i;
        // The in-flight response is consumed here; a new redirect only retargets PC.
        if (imem_ack_i) state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // IF/ID next value: flush, then stall-hold, then skid entry, fresh data or bubble.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (if_id_flash_i) begin
      ifid_valid_d = 1'b0;
      ifid_pc_d    = '0;
      ifid_instr_d = IW'(NOP_INSTR);
    end else if (if_id_write_i) begin
      if (skid_drain && skid_valid) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = skid_pc;
        ifid_instr_d = skid_data;
      end else if (fetch_ok) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = pc_q;
        ifid_instr_d = imem_rdata_i;
      end else begin
        ifid_valid_d = 1'b0;
        ifid_pc_d    = '0;
        ifid_instr_d = IW'(NOP_INSTR);
      end
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= IW'(NOP_INSTR);
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign if_id_valid_o = ifid_valid_q;
  assign if_id_pc_o    = ifid_pc_q;
  assign if_id_instr_o = ifid_instr_q;
  assign if_id_op1_o   = ifid_instr_q[IW-5 -: DS];
  assign if_id_op2_o   = ifid_instr_q[IW-5-DS -: DS];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, if_id_write, if_id_flash, redirect;
  logic [15:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_rdata;
  logic        if_id_valid;
  logic [15:0] if_id_pc, if_id_instr;
  logic [3:0]  if_id_op1, if_id_op2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pc_write_i    (pc_write),
    .if_id_write_i (if_id_write),
    .if_id_flash_i (if_id_flash),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .if_id_valid_o (if_id_valid),
    .if_id_pc_o    (if_id_pc),
    .if_id_instr_o (if_id_instr),
    .if_id_op1_o   (if_id_op1),
    .if_id_op2_o   (if_id_op2)
  );

  // Memory responder: data = 0x1230 + address, latency 'lat' cycles (0 = same cycle).
  int          lat = 0;
  logic        force_ack = 1'b0;
  logic        mem_pend;
  int          mem_cnt;
  logic [15:0] mem_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
      mem_addr <= '0;
    end else if (mem_pend) begin
      if (mem_cnt == 0) mem_pend <= 1'b0;
      else mem_cnt <= mem_cnt - 1;
    end else if (imem_req && lat > 0) begin
      mem_pend <= 1'b1;
      mem_cnt  <= lat - 1;
      mem_addr <= imem_addr;
    end
  end

  assign imem_ack   = force_ack || (mem_pend && mem_cnt == 0) || (!mem_pend && lat == 0 && imem_req);
  assign imem_rdata = 16'h1230 + (mem_pend ? mem_addr : imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: an instruction stream view (one parked instruction, a
  // pending discard, a PC) giving what IF/ID and the memory port must show.
  bit          m_started, m_discard;
  logic [15:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_v;
  logic [15:0] m_ifpc, m_ifinstr;

  always begin
    bit          exp_req, fresh, have_skid, kill, src_ok;
    logic [31:0] src;
    @(negedge clk);
    #3;
    if (!rst_n) begin
      m_started = 0; m_discard = 0; m_pc = 16'h0000; m_q.delete();
      m_v = 0; m_ifpc = 0; m_ifinstr = 0;
    end else begin
      exp_req = m_started && !m_discard && (m_q.size() == 0);
      chk("model_req", imem_req, exp_req);
      if (exp_req) chk("model_addr", imem_addr, m_pc);
      chk("model_valid", if_id_valid, m_v);
      chk("model_ifpc", if_id_pc, m_ifpc);
      chk("model_instr", if_id_instr, m_ifinstr);
      chk("model_op1", if_id_op1, (m_ifinstr >> 8) & 16'hF);
      chk("model_op2", if_id_op2, (m_ifinstr >> 4) & 16'hF);

      fresh     = exp_req && imem_ack && !redirect;
      have_skid = m_q.size() != 0;
      kill      = have_skid && (redirect || if_id_flash);
      src_ok    = 0;
      src       = 0;
      if (have_skid && !kill) begin src = m_q[0]; src_ok = 1; end
      else if (fresh) begin src = {m_pc, imem_rdata}; src_ok = 1; end

      if (if_id_flash) begin
        m_v = 0; m_ifpc = 0; m_ifinstr = 0;
      end else if (if_id_write) begin
        if (src_ok) begin m_v = 1; m_ifpc = src[31:16]; m_ifinstr = src[15:0]; end
        else begin m_v = 0; m_ifpc = 0; m_ifinstr = 0; end
      end

      if (kill || (have_skid && if_id_write)) m_q.delete();
      if (fresh && !if_id_write) m_q.push_back({m_pc, imem_rdata});

      if (m_started) begin
        if (m_discard && imem_ack) m_discard = 0;
        else if (exp_req && !imem_ack && redirect) m_discard = 1;
        if (redirect) m_pc = redirect_pc;
        else if (fresh && pc_write) m_pc = m_pc + 16'h1;
      end
      m_started = 1;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic [47:0] wr_pat, pw_pat, rd_pat, fl_pat;
    wr_pat = 48'hF7BD_E6FA_5B3F;
    pw_pat = 48'hFFEF_FDFF_7FFF;
    rd_pat = 48'h0410_0082_0100;
    fl_pat = 48'h0020_1000_0408;

    rst_n = 1'b0; pc_write = 1'b1; if_id_write = 1'b1; if_id_flash = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", if_id_valid, 0);
    chk("rst_ifpc", if_id_pc, 0);
    chk("rst_instr", if_id_instr, 0);
    repeat (2) cyc();

    // Zero-wait streaming from reset.
    rst_n = 1'b1;
    chk("idle_req", imem_req, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("stream_req", imem_req, 1);
      chk("stream_addr", imem_addr, k - 1);
      if (k == 1) chk("stream_first_bubble", if_id_valid, 0);
      if (k >= 2) begin
        chk("stream_valid", if_id_valid, 1);
        chk("stream_ifpc", if_id_pc, k - 2);
      end
      if (k == 2) begin
        chk("stream_instr", if_id_instr, 16'h1230);
        chk("stream_op1", if_id_op1, 2);
        chk("stream_op2", if_id_op2, 3);
      end
    end

    // Stall across the fetch of PC 5.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (imem_req && imem_addr == 16'h0005) found = 1;
    end
    chk("find_pc5", found, 1);
    if_id_write = 1'b0;
    chk("stall_ifpc0", if_id_pc, 4);
    cyc(); chk("hold_req1", imem_req, 0); chk("hold_ifpc1", if_id_pc, 4);
    cyc(); chk("hold_req2", imem_req, 0); chk("hold_ifpc2", if_id_pc, 4);
    cyc(); chk("hold_req3", imem_req, 0); chk("hold_ifpc3", if_id_pc, 4);
    if_id_write = 1'b1;
    cyc(); chk("release_ifpc5", if_id_pc, 5); chk("release_addr6", imem_addr, 6);
    cyc(); chk("release_ifpc6", if_id_pc, 6);

    // Redirect while waiting on a 2-cycle response.
    lat = 2; redirect = 1'b1; redirect_pc = 16'h0040;
    cyc(); redirect = 1'b0; chk("drop_req", imem_req, 0);
    cyc(); chk("drop_valid_r2", if_id_valid, 0);
    cyc(); chk("redir_req", imem_req, 1); chk("redir_addr", imem_addr, 16'h0040);
           chk("drop_valid_r3", if_id_valid, 0);
    cyc();
    cyc(); chk("drop_valid_r5", if_id_valid, 0); lat = 0;
    cyc(); chk("redir_ifpc", if_id_pc, 16'h0040); chk("redir_instr", if_id_instr, 16'h1270);

    // Flush together with write and an acknowledged fetch.
    if_id_flash = 1'b1;
    cyc(); if_id_flash = 1'b0;
    chk("flash_valid", if_id_valid, 0); chk("flash_instr", if_id_instr, 0);
    cyc(); chk("after_flash_ifpc", if_id_pc, 16'h0042);

    // PC wrap at 0xFFFF.
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    cyc(); redirect = 1'b0; chk("wrap_addr_ffff", imem_addr, 16'hFFFF);
    cyc(); chk("wrap_addr_0", imem_addr, 16'h0000); chk("wrap_ifpc", if_id_pc, 16'hFFFF);
           chk("wrap_instr", if_id_instr, 16'h122F);
    cyc(); chk("wrap_ifpc0", if_id_pc, 16'h0000);

    // Reset in the middle of an outstanding request; late ACK in IDLE.
    lat = 2;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("async_req", imem_req, 0); chk("async_valid", if_id_valid, 0);
    chk("async_addr", imem_addr, 0); chk("async_ifpc", if_id_pc, 0); chk("async_instr", if_id_instr, 0);
    cyc(); rst_n = 1'b1; lat = 0; force_ack = 1'b1;
    chk("post_rst_idle_req", imem_req, 0);
    cyc(); force_ack = 1'b0;
    chk("late_ack_valid", if_id_valid, 0); chk("post_rst_addr", imem_addr, 0); chk("post_rst_req", imem_req, 1);
    cyc(); chk("post_rst_ifpc", if_id_pc, 0); chk("post_rst_v", if_id_valid, 1);
           chk("post_rst_instr", if_id_instr, 16'h1230);

    // Mixed stalls, redirects, flushes and latencies checked by the model.
    for (int i = 0; i < 48; i++) begin
      cyc();
      if_id_write = wr_pat[i];
      pc_write    = pw_pat[i];
      redirect    = rd_pat[i];
      if_id_flash = fl_pat[i];
      redirect_pc = 16'h0200 + 16'(i * 16);
      lat         = (i / 8) % 3;
    end
    cyc();
    if_id_write = 1'b1; pc_write = 1'b1; redirect = 1'b0; if_id_flash = 1'b0; lat = 0;
    repeat (8) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
